// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring divider, one quotient bit per clock; lower = quotient, higher = remainder
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sign,
  output logic [WIDTH-1:0] lower,
  output logic [WIDTH-1:0] higher,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  state_t state, state_n;
  logic [CW-1:0] count;
  logic [WIDTH-1:0] quo, rem, dvs;
  logic neg_q, neg_r, dz;
  logic [WIDTH:0] shifted, trial;
  assign shifted = {rem, quo[WIDTH-1]};
  assign trial = shifted - {1'b0, dvs};
  assign busy = state != IDLE;
  always_comb begin
    state_n = state;
    if (state == IDLE) state_n = start ? RUN : IDLE;
    else if (state == RUN) state_n = count == CW'(1) ? FIX : RUN;
    else state_n = IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      quo <= '0;
      rem <= '0;
      dvs <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dz <= 1'b0;
      lower <= '0;
      higher <= '0;
      done <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      state <= state_n;
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          quo <= sign && a[WIDTH-1] ? -a : a;
          dvs <= sign && b[WIDTH-1] ? -b : b;
          rem <= '0;
          count <= CW'(WIDTH);
          neg_q <= sign & (a[WIDTH-1] ^ b[WIDTH-1]);
          neg_r <= sign & a[WIDTH-1];
          dz <= b == '0;
        end
        // A negative trial (MSB set) means the divisor did not fit: keep the shifted remainder.
        RUN: begin
          rem <= trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
          quo <= {quo[WIDTH-2:0], ~trial[WIDTH]};
          count <= count - CW'(1);
        end
        // With a zero divisor the remainder is |a|, so re-applying the dividend sign restores a.
        FIX: begin
          lower <= dz ? '1 : neg_q ? -quo : quo;
          higher <= neg_r ? -rem : rem;
          div_zero <= dz;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed and randomized checks of seq_divider against an arithmetic reference model
module tb_seq_divider;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, sign = 1'b0;
  logic [31:0] a = '0, b = '0, lower, higher;
  logic busy, done, div_zero;
  int checks = 0, failures = 0;

  seq_divider #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .sign(sign),
    .lower(lower), .higher(higher), .busy(busy), .done(done), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [31:0] x, input logic [31:0] y, input logic s,
                                output logic [31:0] q, output logic [31:0] r, output logic z);
    longint lx, ly;
    z = y == 0;
    if (z) begin
      q = '1;
      r = x;
    end else begin
      lx = s ? longint'($signed(x)) : longint'({32'b0, x});
      ly = s ? longint'($signed(y)) : longint'({32'b0, y});
      q = 32'(lx / ly);
      r = 32'(lx % ly);
    end
  endfunction

  task automatic do_op(input string tag, input logic [31:0] x, input logic [31:0] y,
                       input logic s, input int repulse);
    logic [31:0] eq, er, inv;
    logic ez;
    int n;
    model(x, y, s, eq, er, ez);
    @(negedge clk);
    a = x; b = y; sign = s; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; a = $urandom; b = $urandom; sign = $urandom_range(0, 1);
    chk({tag, ".done_pulse"}, {63'b0, done}, 64'd0);
    chk({tag, ".busy"}, {63'b0, busy}, 64'd1);
    n = 1;
    while (!done && n < 100) begin
      if (n == repulse) begin
        start = 1'b1; a = 32'd9; b = 32'd3; sign = 1'b0;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      n++;
    end
    chk({tag, ".latency"}, 64'(n), 64'd34);
    chk({tag, ".lower"}, {32'b0, lower}, {32'b0, eq});
    chk({tag, ".higher"}, {32'b0, higher}, {32'b0, er});
    chk({tag, ".div_zero"}, {63'b0, div_zero}, {63'b0, ez});
    chk({tag, ".busy_done"}, {63'b0, busy}, 64'd0);
    if (!ez) begin
      inv = lower * y + higher;
      chk({tag, ".invariant"}, {32'b0, inv}, {32'b0, x});
    end
  endtask

  initial begin
    int seen;
    logic [31:0] ra, rb;
    #12;
    chk("reset.lower", {32'b0, lower}, 64'd0);
    chk("reset.higher", {32'b0, higher}, 64'd0);
    chk("reset.flags", {61'b0, busy, done, div_zero}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    do_op("u100_7", 32'd100, 32'd7, 1'b0, 0);
    do_op("s-7_2", 32'hFFFFFFF9, 32'd2, 1'b1, 0);
    do_op("s7_-2", 32'd7, 32'hFFFFFFFE, 1'b1, 0);
    do_op("umax_1", 32'hFFFFFFFF, 32'd1, 1'b0, 0);
    do_op("s_ovf", 32'h80000000, 32'hFFFFFFFF, 1'b1, 0);
    do_op("u_dz", 32'h1234, 32'd0, 1'b0, 0);
    do_op("s_dz", 32'h1234, 32'd0, 1'b1, 0);
    do_op("s_dz_neg", 32'hFFFFF000, 32'd0, 1'b1, 0);
    do_op("dz_clear", 32'd50, 32'd5, 1'b0, 0);
    do_op("repulse", 32'd100, 32'd7, 1'b0, 5);
    do_op("in_done", 32'd9, 32'd3, 1'b0, 0);
    @(negedge clk);
    a = 32'd100; b = 32'd7; sign = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid.lower", {32'b0, lower}, 64'd0);
    chk("rst_mid.higher", {32'b0, higher}, 64'd0);
    chk("rst_mid.flags", {61'b0, busy, done, div_zero}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1 if (done || busy) seen++;
    end
    chk("rst_mid.no_done", 64'(seen), 64'd0);
    do_op("after_rst", 32'd1000, 32'd33, 1'b0, 0);
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 600; i++) begin
        ra = $urandom_range(0, 15) == 0 ? 32'h80000000 : $urandom;
        case ($urandom_range(0, 9))
          0: rb = 32'd0;
          1: rb = 32'hFFFFFFFF;
          2: rb = $urandom_range(1, 15);
          3: rb = -($urandom_range(1, 15));
          default: rb = $urandom >> $urandom_range(0, 31);
        endcase
        do_op(s ? "rnd_s" : "rnd_u", ra, rb, s[0], 0);
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
